mm_seq_ctrl: RTL



---
 rtl/mm_seq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mm_seq_ctrl.sv
// Sequencer for C = A*B: loads the operand file, walks every dot product through
// the MAC, writes results back after the MAC latency, then streams C out.
module mm_seq_ctrl #(
   parameter int ROWS    = 3,
   parameter int INNER   = 4,
   parameter int COLS    = 3,
   parameter int MAC_LAT = 2,
   parameter int IDX_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cf_load,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             reg_ld,
   output logic [IDX_W-1:0] load_sel,
   output logic [IDX_W-1:0] a_sel,
   output logic [IDX_W-1:0] b_sel,
   output logic             mac_en,
   output logic             mac_clr,
   output logic             res_wr,
   output logic [IDX_W-1:0] res_sel,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [IDX_W-1:0] dout_sel,
   output logic             busy,
   output logic             done
);

   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] LOAD_LAST = IDX_W'(ROWS * INNER + INNER * COLS - 1);
   localparam logic [IDX_W-1:0] B_BASE    = IDX_W'(ROWS * INNER);
   localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(INNER - 1);
   localparam logic [IDX_W-1:0] J_LAST    = IDX_W'(COLS - 1);
   localparam logic [IDX_W-1:0] I_LAST    = IDX_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] OUT_LAST  = IDX_W'(ROWS * COLS - 1);
   localparam logic [IDX_W-1:0] INNER_W   = IDX_W'(INNER);
   localparam logic [IDX_W-1:0] COLS_W    = IDX_W'(COLS);
   localparam logic [DW-1:0]    D_LAST    = DW'(MAC_LAT - 1);
   localparam logic [DW-1:0]    D_ONE     = DW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN,
      S_OUTPUT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] load_sel_q, load_sel_d;
   logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
   logic [IDX_W-1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
   logic [IDX_W-1:0] dout_sel_q, dout_sel_d;
   logic [DW-1:0]    drain_q, drain_d;

   logic             push;
   logic [IDX_W-1:0] push_idx;
   logic             dl_vld_q [MAC_LAT];
   logic [IDX_W-1:0] dl_idx_q [MAC_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         load_sel_q <= '0;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         a_sel_q    <= '0;
         b_sel_q    <= '0;
         dout_sel_q <= '0;
         drain_q    <= '0;
      end else begin
         state_q    <= state_d;
         load_sel_q <= load_sel_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         a_sel_q    <= a_sel_d;
         b_sel_q    <= b_sel_d;
         dout_sel_q <= dout_sel_d;
         drain_q    <= drain_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_sel_d = load_sel_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      a_sel_d    = a_sel_q;
      b_sel_d    = b_sel_q;
      dout_sel_d = dout_sel_q;
      drain_d    = drain_q;
      case (state_q)
         S_IDLE: begin
            if (cf_load) begin
               state_d    = S_LOAD;
               load_sel_d = '0;
            end
         end
         S_LOAD: begin
            if (load_valid) begin
               if (load_sel_q == LOAD_LAST) begin
                  state_d = S_COMPUTE;
                  i_d     = '0;
                  j_d     = '0;
                  k_d     = '0;
                  a_sel_d = '0;
                  b_sel_d = B_BASE;
               end else begin
                  load_sel_d = load_sel_q + ONE;
               end
            end
         end
         S_COMPUTE: begin
            if (k_q == K_LAST && j_q == J_LAST && i_q == I_LAST) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end else begin
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (j_q == J_LAST) begin
                     j_d = '0;
                     i_d = i_q + ONE;
                  end else begin
                     j_d = j_q + ONE;
                  end
               end else begin
                  k_d = k_q + ONE;
               end
               // Selects are registered from the next indices so they align with mac_en.
               a_sel_d = i_d * INNER_W + k_d;
               b_sel_d = B_BASE + k_d * COLS_W + j_d;
            end
         end
         S_DRAIN: begin
            if (drain_q == D_LAST) begin
               state_d    = S_OUTPUT;
               dout_sel_d = '0;
            end else begin
               drain_d = drain_q + D_ONE;
            end
         end
         S_OUTPUT: begin
            if (dout_ready) begin
               if (dout_sel_q == OUT_LAST) begin
                  state_d = S_DONE;
               end else begin
                  dout_sel_d = dout_sel_q + ONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign push     = (state_q == S_COMPUTE) && (k_q == K_LAST);
   assign push_idx = i_q * COLS_W + j_q;

   // Stage 0 keeps the last pushed index so res_sel holds between writes.
   generate
      for (genvar gi = 0; gi < MAC_LAT; gi++) begin : g_dline
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) begin
                  dl_vld_q[0] <= 1'b0;
                  dl_idx_q[0] <= '0;
               end else begin
                  dl_vld_q[0] <= push;
                  if (push) begin
                     dl_idx_q[0] <= push_idx;
                  end
               end
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (reset) begin
                  dl_vld_q[gi] <= 1'b0;
                  dl_idx_q[gi] <= '0;
               end else begin
                  dl_vld_q[gi] <= dl_vld_q[gi-1];
                  dl_idx_q[gi] <= dl_idx_q[gi-1];
               end
            end
         end
      end
   endgenerate

   assign load_ready = (state_q == S_LOAD);
   assign reg_ld     = load_valid & load_ready;
   assign load_sel   = load_sel_q;
   assign a_sel      = a_sel_q;
   assign b_sel      = b_sel_q;
   assign mac_en     = (state_q == S_COMPUTE);
   assign mac_clr    = (state_q == S_COMPUTE) && (k_q == '0);
   assign res_wr     = dl_vld_q[MAC_LAT-1];
   assign res_sel    = dl_idx_q[MAC_LAT-1];
   assign dout_valid = (state_q == S_OUTPUT);
   assign dout_sel   = dout_sel_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);

endmodule
